ddd_slave: RTL and testbench
============================

DDD_SLAVE -- requirements
Module: ddd_slave

Interface
REQ-001 clock  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-002 global_reset  in  1  reset, asynchronous and active-high.
REQ-003 serial_clock  in  1  3D3444-style serial clock from the programming master, asynchronous to clock.
REQ-004 serial_out  in  1  serial data from the master, valid at serial_clock rising edge.
REQ-005 adr_latch  in  1  address-latch strobe: idle high, low pulse during the latch step.
REQ-006 serial_in  out  1  readback data to the master (verify path).
REQ-007 oe  out  4  latched output enables.
REQ-008 delay_ch0..delay_ch3  out  4 each  latched channel delay steps.
REQ-009 latched  out  1  one-clock pulse when a valid frame is latched.
REQ-010 frame_err  out  1  sticky: last latch attempt had a bit count other than 20.
REQ-011 latch_cnt  out  8  count of valid latches, wraps 255->0.
REQ-012 Parameter IDLE_TMO, default 16: clocks without a serial_clock edge before the bit counter clears.

Function
REQ-013 serial_clock, serial_out and adr_latch SHALL each pass through a 2-FF synchronizer; edges SHALL be detected from stage 2 vs a third delayed stage.
REQ-014 On a detected serial_clock rising edge, the 20-bit receive register SHALL shift left with stage-2 serial_out entering bit 0 (first bit received ends in bit 19).
REQ-015 serial_in SHALL be registered and equal receive-register bit 19, updating the clock after each shift; readback therefore echoes the prior frame MSB-first.
REQ-016 Bit counter (5 bits) SHALL increment per detected serial_clock rise, saturating at 31.
REQ-017 Idle timer SHALL clear on every serial_clock rise; after IDLE_TMO consecutive clocks without one, the bit counter SHALL clear; the receive register SHALL NOT clear.
REQ-018 On a detected adr_latch rising edge (end of low pulse) with bit counter == 20: oe<=rx[19:16], delay_ch0<=rx[15:12], delay_ch1<=rx[11:8], delay_ch2<=rx[7:4], delay_ch3<=rx[3:0]; latched pulses 1 clock; latch_cnt increments; frame_err clears.
REQ-019 On adr_latch rise with bit counter != 20: config outputs unchanged, latched stays 0, frame_err sets.
REQ-020 Every adr_latch rise SHALL clear the bit counter, even when the frame is rejected.
REQ-021 A serial_clock rise and an adr_latch rise detected in the same clock: the shift SHALL occur first and be included in the count tested by REQ-018/019.
REQ-022 adr_latch falling edges and serial_clock falling edges SHALL have no effect.
REQ-023 Control states: IDLE (count 0), SHIFT (count 1-31), LATCH (1-cycle update); transitions IDLE->SHIFT on first sclk rise, SHIFT->LATCH on adr_latch rise, SHIFT->IDLE on timeout, LATCH->IDLE unconditionally; adr_latch rise in IDLE -> LATCH (count 0, so frame_err).

Reset
REQ-024 Asserting global_reset at any time, including mid-frame, SHALL immediately clear all synchronizers, the receive register, counters and timer; serial_in=0, oe=0, delay_ch0..3=0, latched=0, frame_err=0, latch_cnt=0; state IDLE.
REQ-025 After deassertion, the first frame SHALL be accepted only if all 20 bits arrive after reset.

Verification
REQ-026 Send 20 bits for oe=F, ch0=3, ch1=5, ch2=A, ch3=C, at 2-clock sclk period, then pulse adr_latch -> oe=F, delay_ch0=3, delay_ch1=5, delay_ch2=A, delay_ch3=C; latched one pulse; latch_cnt=1; frame_err=0.
REQ-027 After REQ-026, send a second 20-bit frame (all ones) with no latch -> serial_in sequence equals F,3,5,A,C MSB-first (20 bits); outputs unchanged.
REQ-028 Send 19 bits then latch -> frame_err=1, outputs hold previous values, latch_cnt unchanged; next valid frame -> frame_err=0.
REQ-029 Send 20 stray bits, wait 20 clocks idle, send 20 valid bits (0x12345), latch -> accepted: oe=1, delay_ch0=2, delay_ch1=3, delay_ch2=4, delay_ch3=5.
REQ-030 Assert global_reset after 10 bits of a frame, release, send 10 more bits and latch -> rejected, frame_err=1, all config outputs 0.
REQ-031 Perform 256 valid latches -> latch_cnt wraps to 0.

Source files
------------

// File: rtl/ddd_slave.sv
// ddd_slave: receive side of a 3D3444-style serial programming link.
//
// A master shifts 20-bit frames in on serial_clock/serial_out. A rising edge
// of adr_latch, at the end of its low pulse, commits the frame to the output
// registers. The frame is committed only if exactly 20 bits were received
// since the previous latch, timeout or reset. serial_in echoes the previous
// frame MSB-first as the new frame shifts in, so the master can verify it.
//
// Ports:
//   clock        in   system clock, rising edge
//   global_reset in   asynchronous active-high reset
//   serial_clock in   serial clock from the master (asynchronous to clock)
//   serial_out   in   serial data from the master
//   adr_latch    in   latch strobe, idle high, low pulse to latch
//   serial_in    out  readback bit (receive register bit 19, registered)
//   oe           out  latched output enables
//   delay_ch0..3 out  latched per-channel delay steps
//   latched      out  one-clock pulse when a frame is accepted
//   frame_err    out  sticky: last latch attempt did not have 20 bits
//   latch_cnt    out  number of accepted latches, wraps 255 -> 0
module ddd_slave #(
  parameter int IDLE_TMO = 16
) (
  input  logic       clock,
  input  logic       global_reset,
  input  logic       serial_clock,
  input  logic       serial_out,
  input  logic       adr_latch,
  output logic       serial_in,
  output logic [3:0] oe,
  output logic [3:0] delay_ch0,
  output logic [3:0] delay_ch1,
  output logic [3:0] delay_ch2,
  output logic [3:0] delay_ch3,
  output logic       latched,
  output logic       frame_err,
  output logic [7:0] latch_cnt
);

  localparam int TW = $clog2(IDLE_TMO + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state, state_nxt;
  logic          sclk_p0, sclk_p1, sclk_p2;
  logic          sdo_p0, sdo_p1, sdo_p2;
  logic          adr_p0, adr_p1, adr_p2;
  logic [19:0]   rx;
  logic [19:0]   rx_eff;
  logic [4:0]    cnt;
  logic [4:0]    cnt_eff;
  logic [TW-1:0] tmr;
  logic          sclk_rise, adr_rise, tmo, frame_ok;

  // Edges are taken from synchronizer stage 2 against the delayed stage 3.
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign adr_rise  = adr_p1 & ~adr_p2;
  assign tmo       = ~sclk_rise && (tmr == TW'(IDLE_TMO - 1));

  // Shift and count as they will be after this clock, so a serial_clock edge
  // coinciding with the latch edge is part of the frame being tested.
  assign rx_eff   = sclk_rise ? {rx[18:0], sdo_p1} : rx;
  assign cnt_eff  = sclk_rise ? ((cnt == 5'd31) ? 5'd31 : cnt + 5'd1)
                              : (tmo ? 5'd0 : cnt);
  assign frame_ok = adr_rise && (cnt_eff == 5'd20);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (adr_rise)       state_nxt = LATCH;
        else if (sclk_rise) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (adr_rise) state_nxt = LATCH;
        else if (tmo) state_nxt = IDLE;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer stages p0/p1/p2. The adr_latch chain resets to its idle-high
  // level so that releasing reset is not mistaken for the end of a latch pulse.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      sdo_p0  <= 1'b0;
      sdo_p1  <= 1'b0;
      sdo_p2  <= 1'b0;
      adr_p0  <= 1'b1;
      adr_p1  <= 1'b1;
      adr_p2  <= 1'b1;
    end else begin
      sclk_p0 <= serial_clock;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      sdo_p0  <= serial_out;
      sdo_p1  <= sdo_p0;
      sdo_p2  <= sdo_p1;
      adr_p0  <= adr_latch;
      adr_p1  <= adr_p0;
      adr_p2  <= adr_p1;
    end
  end

  // Receive path, bit counter and idle timer.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state     <= IDLE;
      rx        <= '0;
      serial_in <= 1'b0;
      cnt       <= '0;
      tmr       <= '0;
    end else begin
      state     <= state_nxt;
      rx        <= rx_eff;
      serial_in <= rx[19];
      cnt       <= adr_rise ? 5'd0 : cnt_eff;
      if (sclk_rise)
        tmr <= '0;
      else if (tmr != TW'(IDLE_TMO))
        tmr <= tmr + TW'(1);
    end
  end

  // Configuration outputs and latch status.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      oe        <= '0;
      delay_ch0 <= '0;
      delay_ch1 <= '0;
      delay_ch2 <= '0;
      delay_ch3 <= '0;
      latched   <= 1'b0;
      frame_err <= 1'b0;
      latch_cnt <= '0;
    end else begin
      latched <= frame_ok;
      if (adr_rise)
        frame_err <= ~frame_ok;
      if (frame_ok) begin
        oe        <= rx_eff[19:16];
        delay_ch0 <= rx_eff[15:12];
        delay_ch1 <= rx_eff[11:8];
        delay_ch2 <= rx_eff[7:4];
        delay_ch3 <= rx_eff[3:0];
        latch_cnt <= latch_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddd_slave.sv
// Self-checking bench for ddd_slave: directed frames, readback, framing
// errors, idle timeout, mid-frame reset and latch counter wrap.
module tb_ddd_slave;

  logic       clock;
  logic       global_reset;
  logic       serial_clock;
  logic       serial_out;
  logic       adr_latch;
  logic       serial_in;
  logic [3:0] oe, delay_ch0, delay_ch1, delay_ch2, delay_ch3;
  logic       latched;
  logic       frame_err;
  logic [7:0] latch_cnt;
  logic [19:0] cfg;

  int errors = 0;
  int checks = 0;

  logic [19:0] sbq[$];   // expected configuration per accepted latch
  logic        rbq[$];   // expected readback bits

  assign cfg = {oe, delay_ch0, delay_ch1, delay_ch2, delay_ch3};

  ddd_slave #(.IDLE_TMO(16)) dut (
    .clock       (clock),
    .global_reset(global_reset),
    .serial_clock(serial_clock),
    .serial_out  (serial_out),
    .adr_latch   (adr_latch),
    .serial_in   (serial_in),
    .oe          (oe),
    .delay_ch0   (delay_ch0),
    .delay_ch1   (delay_ch1),
    .delay_ch2   (delay_ch2),
    .delay_ch3   (delay_ch3),
    .latched     (latched),
    .frame_err   (frame_err),
    .latch_cnt   (latch_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Send bits v[hi] down to v[lo], MSB first, 2-clock serial_clock period.
  // With rb set, wait for the previous shift to settle and check serial_in
  // against the readback queue before each bit.
  task automatic send_bits(input logic [19:0] v, input int hi, input int lo, input bit rb);
    for (int i = hi; i >= lo; i--) begin
      if (rb) begin
        tick(3);
        if (rbq.size() > 0) check("readback", serial_in, rbq.pop_front());
        else check("readback_queue", rbq.size(), 1);
      end
      serial_out   = v[i];
      serial_clock = 1'b0;
      tick(1);
      serial_clock = 1'b1;
      tick(1);
    end
    serial_clock = 1'b0;
    tick(1);
  endtask

  // Pulse adr_latch low and watch latched for a bounded number of clocks.
  task automatic do_latch(input bit accept, input logic [19:0] exp);
    int seen;
    seen = 0;
    if (accept) sbq.push_back(exp);
    adr_latch = 1'b0;
    tick(2);
    adr_latch = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (latched) begin
        seen++;
        if (seen == 1 && sbq.size() > 0) check("latch_cfg", cfg, sbq.pop_front());
      end
    end
    check("latch_pulses", seen, accept ? 1 : 0);
  endtask

  initial begin
    logic [19:0] v;
    global_reset = 1'b1;
    serial_clock = 1'b0;
    serial_out   = 1'b0;
    adr_latch    = 1'b1;
    tick(3);

    // Reset state
    check("rst_cfg", cfg, 20'h0);
    check("rst_serial_in", serial_in, 0);
    check("rst_latched", latched, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_latch_cnt", latch_cnt, 0);
    global_reset = 1'b0;
    tick(5);
    check("post_rst_frame_err", frame_err, 0);
    check("post_rst_latched", latched, 0);

    // Valid frame F35AC
    send_bits(20'hF35AC, 19, 0, 0);
    do_latch(1, 20'hF35AC);
    check("f1_latch_cnt", latch_cnt, 1);
    check("f1_frame_err", frame_err, 0);

    // All-ones frame without latch: readback echoes F35AC MSB-first
    v = 20'hF35AC;
    for (int i = 19; i >= 0; i--) rbq.push_back(v[i]);
    send_bits(20'hFFFFF, 19, 0, 1);
    tick(3);
    check("rb_cfg_hold", cfg, 20'hF35AC);
    check("rb_latch_cnt", latch_cnt, 1);
    check("rb_latched", latched, 0);
    tick(20);

    // 19 bits then latch: rejected
    send_bits(20'hABCDE, 18, 0, 0);
    do_latch(0, 20'h0);
    check("short_frame_err", frame_err, 1);
    check("short_cfg_hold", cfg, 20'hF35AC);
    check("short_latch_cnt", latch_cnt, 1);
    send_bits(20'h6789A, 19, 0, 0);
    do_latch(1, 20'h6789A);
    check("recover_frame_err", frame_err, 0);
    check("recover_latch_cnt", latch_cnt, 2);

    // Stray bits, idle timeout, then a valid frame
    send_bits(20'h55555, 19, 0, 0);
    tick(20);
    send_bits(20'h12345, 19, 0, 0);
    do_latch(1, 20'h12345);
    check("tmo_oe", oe, 4'h1);
    check("tmo_ch3", delay_ch3, 4'h5);
    check("tmo_frame_err", frame_err, 0);
    check("tmo_latch_cnt", latch_cnt, 3);

    // Reset in the middle of a frame
    send_bits(20'hFEDCB, 19, 10, 0);
    global_reset = 1'b1;
    tick(2);
    check("midrst_cfg", cfg, 20'h0);
    check("midrst_latch_cnt", latch_cnt, 0);
    global_reset = 1'b0;
    tick(3);
    send_bits(20'hFEDCB, 9, 0, 0);
    do_latch(0, 20'h0);
    check("midrst_frame_err", frame_err, 1);
    check("midrst_cfg_after", cfg, 20'h0);
    check("midrst_cnt_after", latch_cnt, 0);

    // 256 valid latches wrap the counter
    for (int n = 1; n <= 256; n++) begin
      v = 20'(n * 4099 + 7);
      send_bits(v, 19, 0, 0);
      do_latch(1, v);
      if (n == 255) check("wrap_255", latch_cnt, 255);
    end
    check("wrap_0", latch_cnt, 0);
    check("wrap_frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
